irq_ctrl: RTL



---
 rtl/irq_ctrl_pkg.sv | 20 ++
 rtl/irq_prio_enc.sv | 25 ++
 rtl/irq_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, the "no ID"
// value, the CTRL bit layout, and a byte-strobe expansion helper.
package irq_ctrl_pkg;

  localparam logic [4:0] OFS_PENDING   = 5'h00;
  localparam logic [4:0] OFS_ENABLE    = 5'h04;
  localparam logic [4:0] OFS_TYPE      = 5'h08;
  localparam logic [4:0] OFS_CLAIM     = 5'h0C;
  localparam logic [4:0] OFS_CTRL      = 5'h10;
  localparam logic [4:0] OFS_INSERVICE = 5'h14;

  localparam int ID_NONE = 0;
  localparam int GIE_BIT = 0;

  // Expands the four byte strobes into a 32-bit bit-enable mask.
  function automatic logic [31:0] strobe_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set bit wins and is reported as ID bit+1.
// Feeds both the registered irq line and the CLAIM read path.
module irq_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic [NUM_SRC-1:0] eligible,
  output logic               valid,
  output logic [ID_W-1:0]    id
);
  import irq_ctrl_pkg::*;

  // Scanning downward lets the lowest index overwrite any higher winner.
  always_comb begin
    valid = 1'b0;
    id    = ID_W'(ID_NONE);
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid = 1'b1;
        id    = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped edge/level interrupt controller with claim/complete.
// Define IRQ_SYNC_EN to put a 2-flop synchronizer on every irq_src bit.
module irq_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  input  logic               rstrb,
  output logic [31:0]        rdata,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq
);
  import irq_ctrl_pkg::*;

  logic [NUM_SRC-1:0] sampled;
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] src_type;
  logic [NUM_SRC-1:0] inservice;
  logic               gie;

  logic [NUM_SRC-1:0] eligible;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;

  logic [2:0]         sel;
  logic [31:0]        wmask;
  logic               wr_pending;
  logic               wr_enable;
  logic               wr_type;
  logic               wr_complete;
  logic               wr_ctrl;
  logic               claim;
  logic [ID_W-1:0]    cpl_id;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] claim_mask;
  logic [NUM_SRC-1:0] complete_mask;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] pending_next;
  logic [31:0]        rd_value;
  logic               unused_bits;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign sampled = sync2;
`else
  assign sampled = irq_src;
`endif

  assign sel         = addr[4:2];
  assign wmask       = strobe_mask(wstrb);
  assign wr_pending  = (|wstrb) && (sel == OFS_PENDING[4:2]);
  assign wr_enable   = (|wstrb) && (sel == OFS_ENABLE[4:2]);
  assign wr_type     = (|wstrb) && (sel == OFS_TYPE[4:2]);
  assign wr_complete = wstrb[0] && (sel == OFS_CLAIM[4:2]);
  assign wr_ctrl     = wstrb[0] && (sel == OFS_CTRL[4:2]);
  assign claim       = rstrb && (sel == OFS_CLAIM[4:2]);
  assign cpl_id      = wdata[ID_W-1:0];
  assign unused_bits = ^{addr[31:5], addr[1:0], wdata};

  assign eligible = pending & enable & ~inservice;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .eligible (eligible),
    .valid    (win_valid),
    .id       (win_id)
  );

  // ID 0 and IDs above NUM_SRC match no bit, so they fall out as no-ops.
  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_mask[i]    = claim && win_valid && (win_id == ID_W'(i + 1));
      complete_mask[i] = wr_complete && (cpl_id == ID_W'(i + 1));
    end
  end

  assign w1c_mask = wr_pending ? NUM_SRC'(wdata & wmask) : '0;
  assign edge_det = sampled & ~prev;

  // A fresh edge beats both W1C and claim, so a coincident request is never lost.
  assign pending_next = (src_type & (edge_det | (pending & ~w1c_mask & ~claim_mask)))
                      | (~src_type & sampled);

  always_comb begin
    rd_value = '0;
    case (sel)
      OFS_PENDING[4:2]:   rd_value = 32'(pending);
      OFS_ENABLE[4:2]:    rd_value = 32'(enable);
      OFS_TYPE[4:2]:      rd_value = 32'(src_type);
      OFS_CLAIM[4:2]:     rd_value = 32'(win_id);
      OFS_CTRL[4:2]:      rd_value = 32'(gie);
      OFS_INSERVICE[4:2]: rd_value = 32'(inservice);
      default:            rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      pending   <= '0;
      inservice <= '0;
    end else begin
      prev      <= sampled;
      pending   <= pending_next;
      inservice <= (inservice & ~complete_mask) | claim_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= '0;
      src_type <= '0;
      gie      <= 1'b0;
    end else begin
      if (wr_enable) enable <= NUM_SRC'((32'(enable) & ~wmask) | (wdata & wmask));
      if (wr_type) src_type <= NUM_SRC'((32'(src_type) & ~wmask) | (wdata & wmask));
      if (wr_ctrl) gie <= wdata[GIE_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq   <= 1'b0;
      rdata <= '0;
    end else begin
      irq <= gie & win_valid;
      if (rstrb) rdata <= rd_value;
    end
  end

endmodule
